// File: rtl/sm_rf_pkg.sv
// Shared types and helpers for the SM register-file port arbiter slice.
package sm_rf_pkg;

  localparam int DEFAULT_REG_WIDTH = 32;
  localparam int DEFAULT_NUM_RD    = 4;

  // Requester tag for the default read-port count.
  typedef logic [$clog2(DEFAULT_NUM_RD)-1:0] rd_tag_t;

  function automatic int rf_addr_w(input int threads, input int regs);
    return $clog2(threads * regs);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, pointer advances past the winner.
module rr_arbiter
  import sm_rf_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  generate
    if (N == 1) begin : g_pass
      assign grant = valid;
      assign idx   = '0;
    end else begin : g_rr
      logic [IW-1:0] ptr_reg;
      logic          found;

      always_comb begin : p_search
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        // Scan from the pointer upward, wrapping to 0.
        for (int k = 0; k < N; k++) begin
          j = int'(ptr_reg) + k;
          if (j >= N) j = j - N;
          if (!found && valid[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            found    = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_reg <= '0;
        end else if (found) begin
          ptr_reg <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sm_rf_port_arbiter.sv
// Shares one register file between several read and write requesters: RR grants,
// 2-cycle tagged read pipeline, same-cycle write-to-read forwarding, stall counter.
module sm_rf_port_arbiter
  import sm_rf_pkg::*;
#(
  parameter int NUM_RD          = 4,
  parameter int NUM_WR          = 2,
  parameter int NUM_THREADS     = 256,
  parameter int REGS_PER_THREAD = 16,
  parameter int REG_WIDTH       = DEFAULT_REG_WIDTH,
  localparam int AW             = rf_addr_w(NUM_THREADS, REGS_PER_THREAD)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RD-1:0]           rd_req_valid,
  input  logic [NUM_RD*AW-1:0]        rd_req_addr,
  output logic [NUM_RD-1:0]           rd_req_ready,
  output logic [NUM_RD-1:0]           rd_rsp_valid,
  output logic [REG_WIDTH-1:0]        rd_rsp_data,
  input  logic [NUM_WR-1:0]           wr_req_valid,
  input  logic [NUM_WR*AW-1:0]        wr_req_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0] wr_req_data,
  output logic [NUM_WR-1:0]           wr_req_ready,
  output logic                        rf_wr_en,
  output logic [AW-1:0]               rf_wr_addr,
  output logic [REG_WIDTH-1:0]        rf_wr_data,
  output logic [AW-1:0]               rf_rd_addr,
  input  logic [REG_WIDTH-1:0]        rf_rd_data,
  output logic [31:0]                 rd_stall_cnt
);

  localparam int RIW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int WIW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [NUM_RD-1:0]    rd_grant;
  logic [RIW-1:0]       rd_idx;
  logic [NUM_WR-1:0]    wr_grant;
  logic [WIW-1:0]       wr_idx;
  logic                 rd_any;
  logic                 wr_any;
  logic [AW-1:0]        rd_sel_addr;
  logic                 rd_fwd;
  logic                 rd_stall;
  logic [NUM_RD-1:0]    rsp_onehot;

  logic                 s1_valid_reg;
  logic [RIW-1:0]       s1_id_reg;
  logic                 s1_fwd_reg;
  logic [REG_WIDTH-1:0] s1_fwd_data_reg;
  logic [AW-1:0]        rd_addr_hold_reg;

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (rd_req_valid),
    .grant (rd_grant),
    .idx   (rd_idx)
  );

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (wr_req_valid),
    .grant (wr_grant),
    .idx   (wr_idx)
  );

  assign rd_req_ready = rd_grant;
  assign wr_req_ready = wr_grant;
  assign rd_any       = |rd_grant;
  assign wr_any       = |wr_grant;
  assign rf_wr_en     = wr_any;

  always_comb begin
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    rd_sel_addr = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_any && wr_idx == WIW'(i)) begin
        rf_wr_addr = wr_req_addr[i*AW +: AW];
        rf_wr_data = wr_req_data[i*REG_WIDTH +: REG_WIDTH];
      end
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_any && rd_idx == RIW'(i)) rd_sel_addr = rd_req_addr[i*AW +: AW];
    end
  end

  // The RF returns stale data on a same-address collision, so capture the write data instead.
  assign rf_rd_addr = rd_any ? rd_sel_addr : rd_addr_hold_reg;
  assign rd_fwd     = rd_any && rf_wr_en && (rd_sel_addr == rf_wr_addr);
  assign rd_stall   = |(rd_req_valid & ~rd_grant);

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rsp_onehot[i] = s1_valid_reg && (s1_id_reg == RIW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg     <= 1'b0;
      s1_id_reg        <= '0;
      s1_fwd_reg       <= 1'b0;
      s1_fwd_data_reg  <= '0;
      rd_addr_hold_reg <= '0;
      rd_rsp_valid     <= '0;
      rd_rsp_data      <= '0;
      rd_stall_cnt     <= '0;
    end else begin
      s1_valid_reg <= rd_any;
      if (rd_any) begin
        s1_id_reg        <= rd_idx;
        s1_fwd_reg       <= rd_fwd;
        s1_fwd_data_reg  <= rf_wr_data;
        rd_addr_hold_reg <= rd_sel_addr;
      end
      rd_rsp_valid <= rsp_onehot;
      if (s1_valid_reg) begin
        rd_rsp_data <= s1_fwd_reg ? s1_fwd_data_reg : rf_rd_data;
      end
      if (rd_stall && rd_stall_cnt != 32'hFFFF_FFFF) begin
        rd_stall_cnt <= rd_stall_cnt + 32'd1;
      end
    end
  end

endmodule
